// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch states, PC width,
// opcode length-class masks and halt opcode constants.
package cpu_pkg;

  localparam int PC_W = 14;

  typedef enum logic [2:0] {
    F1   = 3'd0,
    F2   = 3'd1,
    F3   = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // 00xxx1x0 -> 2 bytes, 01xxxxx0 -> 3 bytes
  localparam logic [7:0] LEN2_MASK  = 8'hC5;
  localparam logic [7:0] LEN2_MATCH = 8'h04;
  localparam logic [7:0] LEN3_MASK  = 8'hC1;
  localparam logic [7:0] LEN3_MATCH = 8'h40;

  // 0000000x and 11111111 stop the fetch unit
  localparam logic [7:0] HALT_MASK  = 8'hFE;
  localparam logic [7:0] HALT_MATCH = 8'h00;
  localparam logic [7:0] HALT_OP_FF = 8'hFF;

  function automatic logic [1:0] opLength(input logic [7:0] op);
    logic [1:0] len;
    len = LEN_1;
    if ((op & LEN2_MASK) == LEN2_MATCH) len = LEN_2;
    else if ((op & LEN3_MASK) == LEN3_MATCH) len = LEN_3;
    return len;
  endfunction

  function automatic logic isHaltOp(input logic [7:0] op);
    return ((op & HALT_MASK) == HALT_MATCH) || (op == HALT_OP_FF);
  endfunction

endpackage

// File: rtl/cpu_ilen.sv
// Opcode length classifier: returns instruction length (1..3) and a halt
// flag for an 8-bit opcode. Purely combinational, shared with the decoder.
module cpu_ilen
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len,
  output logic       o_halt
);

  assign o_len  = opLength(i_opcode);
  assign o_halt = isHaltOp(i_opcode);

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: reads 1-3 instruction bytes, presents them until
// accepted, handles PC redirect and halt. Optional interrupt-acknowledge
// fetch is enabled by defining CPU_FETCH_INT_EN.
module cpu_fetch
  import cpu_pkg::*;
(
  input  logic            CLK_I,
  input  logic            RST_I,
  output logic            MEM_REQ_O,
  output logic [PC_W-1:0] MEM_ADDR_O,
  input  logic            MEM_ACK_I,
  input  logic [7:0]      MEM_DATA_I,
  output logic [7:0]      IR_O,
  output logic [7:0]      DB2_O,
  output logic [7:0]      DB3_O,
  output logic [1:0]      LEN_O,
  output logic            INSTR_VLD_O,
  input  logic            INSTR_RDY_I,
  input  logic            PC_LD_I,
  input  logic [PC_W-1:0] PC_LD_ADDR_I,
  output logic [PC_W-1:0] PC_O,
  output logic            HALTED_O
`ifdef CPU_FETCH_INT_EN
  ,
  input  logic            INT_I,
  output logic            INT_ACK_O
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_stateNext;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pcNext;
  logic [7:0]      r_ir;
  logic [7:0]      r_db2;
  logic [7:0]      r_db3;
  logic [1:0]      r_len;
  logic            r_isHalt;
  logic            r_intCycle;
  logic            w_fetching;
  logic            w_accept;
  logic            w_ackF1;
  logic [1:0]      w_newLen;
  logic            w_newHalt;

  // Classify the byte on the bus so the F1 ack can choose the next state.
  cpu_ilen u_ilen (
    .i_opcode (MEM_DATA_I),
    .o_len    (w_newLen),
    .o_halt   (w_newHalt)
  );

  assign w_fetching = (r_state == F1) || (r_state == F2) || (r_state == F3);
  assign w_accept   = (r_state == HOLD) && INSTR_RDY_I;
  assign w_ackF1    = (r_state == F1) && MEM_ACK_I;

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      F1: begin
        if (MEM_ACK_I) w_stateNext = (w_newLen == LEN_1) ? HOLD : F2;
      end
      F2: begin
        if (MEM_ACK_I) w_stateNext = (r_len == LEN_3) ? F3 : HOLD;
      end
      F3: begin
        if (MEM_ACK_I) w_stateNext = HOLD;
      end
      HOLD: begin
        if (INSTR_RDY_I) w_stateNext = r_isHalt ? HALT : F1;
      end
      HALT: begin
`ifdef CPU_FETCH_INT_EN
        if (INT_I) w_stateNext = F1;
`endif
      end
      default: w_stateNext = F1;
    endcase
  end

  // An interrupt-acknowledge opcode fetch leaves the PC where it was.
  always_comb begin
    w_pcNext = r_pc;
    if (w_fetching && MEM_ACK_I && !(w_ackF1 && r_intCycle)) begin
      w_pcNext = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (w_accept && PC_LD_I) begin
      w_pcNext = PC_LD_ADDR_I;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= F1;
      r_pc     <= '0;
      r_ir     <= 8'h00;
      r_db2    <= 8'h00;
      r_db3    <= 8'h00;
      r_len    <= LEN_1;
      r_isHalt <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_ackF1) begin
        r_ir     <= MEM_DATA_I;
        r_len    <= w_newLen;
        r_isHalt <= w_newHalt;
      end
      if ((r_state == F2) && MEM_ACK_I) r_db2 <= MEM_DATA_I;
      if ((r_state == F3) && MEM_ACK_I) r_db3 <= MEM_DATA_I;
    end
  end

`ifdef CPU_FETCH_INT_EN
  // Interrupt is sampled on entry to F1 (leaving HOLD) or at any time in HALT.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_intCycle <= 1'b0;
    end else if (w_ackF1) begin
      r_intCycle <= 1'b0;
    end else if (w_accept && !r_isHalt) begin
      r_intCycle <= INT_I;
    end else if ((r_state == HALT) && INT_I) begin
      r_intCycle <= 1'b1;
    end
  end

  assign INT_ACK_O = MEM_REQ_O && (r_state == F1) && r_intCycle;
`else
  assign r_intCycle = 1'b0;
`endif

  assign MEM_REQ_O   = w_fetching && !RST_I;
  assign MEM_ADDR_O  = r_pc;
  assign PC_O        = r_pc;
  assign IR_O        = r_ir;
  assign DB2_O       = r_db2;
  assign DB3_O       = r_db3;
  assign LEN_O       = r_len;
  assign INSTR_VLD_O = (r_state == HOLD);
  assign HALTED_O    = (r_state == HALT);

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed testbench for cpu_fetch: table of fetch vectors plus hand-written
// sequences for wait states, hold, redirect, halt and mid-fetch reset.
module tb_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq;
  logic [13:0] memAddr;
  logic        memAck;
  logic [7:0]  memData;
  logic [7:0]  ir, db2, db3;
  logic [1:0]  len;
  logic        vld;
  logic        rdy;
  logic        pcLd;
  logic [13:0] pcLdAddr;
  logic [13:0] pc;
  logic        halted;
`ifdef CPU_FETCH_INT_EN
  logic        intr;
  logic        intAck;
`endif

  logic [7:0] mem [0:16383];
  int ackDelay;
  int waitCnt;
  logic memEnable;
  logic forceAck;
  int testsRun;
  int testsFailed;

  typedef struct {
    logic [13:0] addr;
    int          n;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  expIr, expDb2, expDb3;
    logic [1:0]  expLen;
    logic [13:0] expPc;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  cpu_fetch dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .MEM_REQ_O    (memReq),
    .MEM_ADDR_O   (memAddr),
    .MEM_ACK_I    (memAck),
    .MEM_DATA_I   (memData),
    .IR_O         (ir),
    .DB2_O        (db2),
    .DB3_O        (db3),
    .LEN_O        (len),
    .INSTR_VLD_O  (vld),
    .INSTR_RDY_I  (rdy),
    .PC_LD_I      (pcLd),
    .PC_LD_ADDR_I (pcLdAddr),
    .PC_O         (pc),
    .HALTED_O     (halted)
`ifdef CPU_FETCH_INT_EN
    ,
    .INT_I        (intr),
    .INT_ACK_O    (intAck)
`endif
  );

  // Memory responder: answers a request after ackDelay idle cycles.
  initial begin
    memAck  = 1'b0;
    memData = 8'h00;
    waitCnt = 0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (forceAck) begin
        memAck  = 1'b1;
        memData = 8'hEE;
      end else if (memReq && memEnable) begin
        if (waitCnt >= ackDelay) begin
          memAck  = 1'b1;
          memData = mem[memAddr];
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [13:0] addr);
    rdy      = r;
    pcLd     = ld;
    pcLdAddr = addr;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 14'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic waitVld(input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles = i + 1;
      if (vld === 1'b1) return;
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL vld_timeout: got no VLD expected VLD within %0d cycles", budget);
  endtask

  task automatic accept(input logic ld, input logic [13:0] addr);
    applyStimulus(1'b1, ld, addr);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 14'h0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int vldCount;
    logic [13:0] a1;
    logic [13:0] a2;
    logic [7:0] haltOps[2];

    testsRun    = 0;
    testsFailed = 0;
    rst       = 1'b1;
    ackDelay  = 0;
    memEnable = 1'b1;
    forceAck  = 1'b0;
`ifdef CPU_FETCH_INT_EN
    intr = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 14'h0);
    for (int i = 0; i < 16384; i++) mem[i] = 8'h80;

    vecs[0]  = '{14'h0000, 2, 8'h0E, 8'h55, 8'h00, 8'h0E, 8'h55, 8'h00, 2'd2, 14'h0002};
    vecs[1]  = '{14'h0100, 3, 8'h44, 8'h34, 8'h12, 8'h44, 8'h34, 8'h12, 2'd3, 14'h0103};
    vecs[2]  = '{14'h3FFF, 1, 8'hC1, 8'h00, 8'h00, 8'hC1, 8'h00, 8'h00, 2'd1, 14'h0000};
    vecs[3]  = '{14'h0200, 2, 8'h06, 8'hAA, 8'h00, 8'h06, 8'hAA, 8'h00, 2'd2, 14'h0202};
    vecs[4]  = '{14'h0300, 3, 8'h7E, 8'h01, 8'h02, 8'h7E, 8'h01, 8'h02, 2'd3, 14'h0303};
    vecs[5]  = '{14'h0400, 1, 8'h41, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 2'd1, 14'h0401};
    vecs[6]  = '{14'h0500, 2, 8'h04, 8'h99, 8'h00, 8'h04, 8'h99, 8'h00, 2'd2, 14'h0502};
    vecs[7]  = '{14'h0600, 1, 8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 2'd1, 14'h0601};
    vecs[8]  = '{14'h0700, 2, 8'h3C, 8'h77, 8'h00, 8'h3C, 8'h77, 8'h00, 2'd2, 14'h0702};
    vecs[9]  = '{14'h0800, 1, 8'hC4, 8'h00, 8'h00, 8'hC4, 8'h00, 8'h00, 2'd1, 14'h0801};
    vecs[10] = '{14'h0A00, 3, 8'h60, 8'hAB, 8'hCD, 8'h60, 8'hAB, 8'hCD, 2'd3, 14'h0A03};

    // Reset values, with MEM_REQ_O low while reset is held.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_regs", {ir, db2, db3, 6'b0, len}, {8'h00, 8'h00, 8'h00, 6'b0, 2'd1});
    checkOutput("rst_flags", {29'b0, vld, halted, memReq}, 32'h0);
    checkOutput("rst_pc", {18'b0, pc}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("req_after_rst", {17'b0, memReq, memAddr}, {17'b0, 1'b1, 14'h0000});

    // Table-driven fetches; a one-byte 0x80 at address 0 redirects to the vector.
    for (int v = 0; v < 11; v++) begin
      a1 = vecs[v].addr + 14'd1;
      a2 = vecs[v].addr + 14'd2;
      mem[vecs[v].addr] = vecs[v].b0;
      if (vecs[v].n >= 2) mem[a1] = vecs[v].b1;
      if (vecs[v].n >= 3) mem[a2] = vecs[v].b2;
      if (vecs[v].addr != 14'h0) mem[0] = 8'h80;
      resetDut();
      if (vecs[v].addr != 14'h0) begin
        waitVld(10, cyc);
        accept(1'b1, vecs[v].addr);
      end
      waitVld(10, cyc);
      checkOutput($sformatf("vec%0d_ir", v), {24'b0, ir}, {24'b0, vecs[v].expIr});
      checkOutput($sformatf("vec%0d_db2", v), {24'b0, db2}, {24'b0, vecs[v].expDb2});
      checkOutput($sformatf("vec%0d_db3", v), {24'b0, db3}, {24'b0, vecs[v].expDb3});
      checkOutput($sformatf("vec%0d_len", v), {30'b0, len}, {30'b0, vecs[v].expLen});
      checkOutput($sformatf("vec%0d_pc", v), {18'b0, pc}, {18'b0, vecs[v].expPc});
      checkOutput($sformatf("vec%0d_req", v), {31'b0, memReq}, 32'h0);
    end

    // Two-byte fetch latency from reset: ack, ack, then VLD.
    mem[0] = 8'h0E;
    mem[1] = 8'h55;
    resetDut();
    waitVld(10, cyc);
    checkOutput("latency_2byte", cyc, 32'd3);
    checkOutput("latency_pc", {18'b0, pc}, {18'b0, 14'h0002});

    // Three wait states: request and address held, single capture.
    mem[0] = 8'h80;
    ackDelay = 3;
    resetDut();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wait_hold%0d", i), {17'b0, memReq, memAddr}, {17'b0, 1'b1, 14'h0000});
    end
    waitVld(10, cyc);
    checkOutput("wait_vld_latency", cyc, 32'd1);
    checkOutput("wait_pc", {18'b0, pc}, {18'b0, 14'h0001});
    ackDelay = 0;

    // PC wrap at 3FFF, then HOLD stable for five cycles without RDY.
    mem[0] = 8'h80;
    mem[14'h3FFF] = 8'hC1;
    resetDut();
    waitVld(10, cyc);
    accept(1'b1, 14'h3FFF);
    waitVld(10, cyc);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_stable%0d", i),
                  {6'b0, vld, memReq, ir, pc, len},
                  {6'b0, 1'b1, 1'b0, 8'hC1, 14'h0000, 2'd1});
      @(negedge clk);
    end

    // Redirect ignored outside accept; honoured on accept after a 3-byte op.
    mem[0] = 8'h44;
    mem[1] = 8'h34;
    mem[2] = 8'h12;
    resetDut();
    applyStimulus(1'b1, 1'b1, 14'h2222);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 14'h0);
    waitVld(10, cyc);
    checkOutput("ld_ignored_pc", {18'b0, pc}, {18'b0, 14'h0003});
    checkOutput("ld_bytes", {6'b0, len, ir, db2, db3}, {6'b0, 2'd3, 8'h44, 8'h34, 8'h12});
    accept(1'b1, 14'h1234);
    @(negedge clk);
    checkOutput("ld_target", {17'b0, memReq, memAddr}, {17'b0, 1'b1, 14'h1234});

    // Halt opcodes stop the fetch unit.
    haltOps[0] = 8'hFF;
    haltOps[1] = 8'h01;
    for (int h = 0; h < 2; h++) begin
      mem[0] = haltOps[h];
      mem[1] = 8'h0D;
      resetDut();
      waitVld(10, cyc);
      accept(1'b0, 14'h0);
`ifdef CPU_FETCH_INT_EN
      intr = 1'b1;
`endif
      @(negedge clk);
      checkOutput($sformatf("halt%0d_enter", h), {29'b0, halted, memReq, vld}, {29'b0, 3'b100});
`ifdef CPU_FETCH_INT_EN
      @(posedge clk); #1;
      intr = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("int%0d_ack", h), {16'b0, intAck, memReq, memAddr}, {16'b0, 2'b11, 14'h0001});
      waitVld(10, cyc);
      checkOutput($sformatf("int%0d_ir", h), {24'b0, ir}, {24'b0, 8'h0D});
      checkOutput($sformatf("int%0d_pc", h), {17'b0, intAck, pc}, {17'b0, 1'b0, 14'h0001});
`else
      applyStimulus(1'b1, 1'b1, 14'h3000);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput($sformatf("halt%0d_stay%0d", h, i), {16'b0, halted, memReq, pc}, {16'b0, 2'b10, 14'h0001});
      end
      applyStimulus(1'b0, 1'b0, 14'h0);
`endif
    end

    // Reset while waiting on byte 2, with a stray ack in the reset cycle.
    mem[0] = 8'h0E;
    mem[1] = 8'h55;
    resetDut();
    @(negedge clk);
    @(posedge clk); #1;
    memEnable = 1'b0;
    @(negedge clk);
    checkOutput("f2_wait", {16'b0, vld, memReq, memAddr}, {16'b0, 2'b01, 14'h0001});
    @(posedge clk); #1;
    rst = 1'b1;
    forceAck = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_low", {31'b0, memReq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    forceAck = 1'b0;
    memEnable = 1'b1;
    @(negedge clk);
    checkOutput("midrst_state", {8'b0, vld, memReq, pc, db2}, {8'b0, 2'b01, 14'h0000, 8'h00});

    // Back-to-back one-byte instructions with RDY held high.
    for (int i = 0; i < 8; i++) mem[i] = 8'h80;
    resetDut();
    rdy = 1'b1;
    vldCount = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (vld === 1'b1) vldCount++;
    end
    rdy = 1'b0;
    checkOutput("throughput", {31'b0, (vldCount >= 3)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
